// File: rtl/sign_restore_pipe_pkg.sv
// ----------------------------------------------------------------------------
// sign_restore_pkg
//   Shared definitions for the sign-restore output stage of the signed
//   approximate-multiplier datapath.
//     W_DEF   default operand width
//     P_W     product width (2*W_DEF)
//     P_MAX   largest positive two's-complement product
//     P_MIN   most negative two's-complement product
//     stage_t stage-1 payload: sign, magnitude and the two overflow flags
//     make_stage  builds a stage_t from sign + magnitude, deriving the flags
// ----------------------------------------------------------------------------
package sign_restore_pkg;

    localparam int W_DEF = 16;
    localparam int P_W   = 2 * W_DEF;

    localparam logic [P_W-1:0] P_MAX = {1'b0, {(P_W-1){1'b1}}};
    localparam logic [P_W-1:0] P_MIN = {1'b1, {(P_W-1){1'b0}}};

    // Payload width is tied to W_DEF; the pipe's W parameter must stay equal to it.
    typedef struct packed {
        logic           sign;
        logic [P_W-1:0] mag;
        logic           pos_ovf;
        logic           neg_ovf;
    } stage_t;

    // A positive result overflows as soon as the top magnitude bit is set.
    // A negative result may reach exactly P_MIN, so only strictly larger
    // magnitudes overflow.
    function automatic stage_t make_stage(input logic sign, input logic [P_W-1:0] mag);
        stage_t st;
        st.sign    = sign;
        st.mag     = mag;
        st.pos_ovf = !sign && mag[P_W-1];
        st.neg_ovf = sign && (mag > P_MIN);
        return st;
    endfunction

endpackage

// File: rtl/sign_restore_pipe_if.sv
// ----------------------------------------------------------------------------
// sign_restore_pipe_if
//   Input and output streams of sign_restore_pipe.
//   Handshake: each stream transfers one beat on a rising clock edge where
//   valid && ready are both high. A producer holds valid and its payload
//   stable until that edge; ready may depend combinationally on the consumer
//   side but never on the valid it is paired with.
//     in_valid/in_ready/in_sign/in_mag      upstream -> pipe
//     out_valid/out_ready/out_data/out_sat  pipe -> downstream
//   modport master: the environment around the pipe
//   modport slave : the pipe itself
// ----------------------------------------------------------------------------
interface sign_restore_pipe_if
    import sign_restore_pkg::*;
#(
    parameter int W = W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [2*W-1:0]   in_mag;

    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_data;
    logic             out_sat;

    modport master (
        output in_valid, in_sign, in_mag, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_sign, in_mag, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/sign_restore_pipe_mag_to_twos.sv
// ----------------------------------------------------------------------------
// mag_to_twos
//   Combinational sign + magnitude to two's-complement conversion with
//   saturation, driven by precomputed overflow flags.
//     sign     in  1      1 = negative result
//     mag      in  2*W    unsigned magnitude
//     pos_ovf  in  1      positive result does not fit
//     neg_ovf  in  1      negative result does not fit
//     data     out 2*W    two's-complement result (clamped on overflow)
//     sat      out 1      result was clamped
// ----------------------------------------------------------------------------
module mag_to_twos
    import sign_restore_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           sign,
    input  logic [2*W-1:0] mag,
    input  logic           pos_ovf,
    input  logic           neg_ovf,
    output logic [2*W-1:0] data,
    output logic           sat
);
    localparam logic [2*W-1:0] MAX_V = {1'b0, {(2*W-1){1'b1}}};
    localparam logic [2*W-1:0] MIN_V = {1'b1, {(2*W-1){1'b0}}};

    always_comb begin
        data = mag;
        sat  = 1'b0;
        if (pos_ovf) begin
            data = MAX_V;
            sat  = 1'b1;
        end else if (neg_ovf) begin
            data = MIN_V;
            sat  = 1'b1;
        end else if (sign) begin
            // mag == 0 negates to 0, so there is no negative zero.
            // mag == MIN_V negates to itself, the legal minimum.
            data = ~mag + 1'b1;
        end
    end
endmodule

// File: rtl/sign_restore_pipe.sv
// ----------------------------------------------------------------------------
// sign_restore_pipe
//   Output end of the signed approximate-multiplier datapath: turns the core's
//   unsigned product magnitude plus result sign into a saturated
//   two's-complement product through a 2-stage valid/ready pipeline, and
//   counts delivered saturated results.
//     clk      in   1      rising-edge clock
//     rst_n    in   1      synchronous active-low reset
//     bus      slave modport of sign_restore_pipe_if (in/out streams)
//     sat_clr  in   1      synchronous clear of sat_cnt (wins over increment)
//     sat_cnt  out  CNT_W  saturated results delivered, sticks at all-ones
// ----------------------------------------------------------------------------
module sign_restore_pipe
    import sign_restore_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    sign_restore_pipe_if.slave bus,
    input  logic             sat_clr,
    output logic [CNT_W-1:0] sat_cnt
);
    logic           s1_valid;
    logic           s2_valid;
    logic           s1_adv;
    logic           s2_adv;
    logic           out_xfer;

    stage_t         s1_d;
    stage_t         s1_q;

    logic [2*W-1:0] m2t_data;
    logic           m2t_sat;
    logic [2*W-1:0] s2_data;
    logic           s2_sat;

    // Ready chain: a stage may load when it is empty or its content leaves
    // this cycle. in_ready never looks at in_valid.
    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    assign out_xfer     = s2_valid && bus.out_ready;

    assign s1_d = make_stage(bus.in_sign, bus.in_mag);

    mag_to_twos #(
        .W(W)
    ) u_mag_to_twos (
        .sign    (s1_q.sign),
        .mag     (s1_q.mag),
        .pos_ovf (s1_q.pos_ovf),
        .neg_ovf (s1_q.neg_ovf),
        .data    (m2t_data),
        .sat     (m2t_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_sat   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_q <= s1_d;
                end
            end
            // Payload only moves with a valid beat, so a stalled or idle
            // output keeps its last data unchanged.
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= m2t_data;
                    s2_sat  <= m2t_sat;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (out_xfer && s2_sat && (sat_cnt != {CNT_W{1'b1}})) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_sat   = s2_sat;

endmodule
